// File: rtl/rr_mux_arbiter_if.sv
// Handshake/data bundle between four requesters, the arbiter and its downstream sink.
// slave modport is the arbiter's view; master modport is the requester/sink side.
interface rr_mux_arbiter_if #(
  parameter int N = 8
);
  logic [3:0]   req;
  logic [3:0]   lst;
  logic [N-1:0] d0;
  logic [N-1:0] d1;
  logic [N-1:0] d2;
  logic [N-1:0] d3;
  logic [3:0]   ack;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic [1:0]   out_src;
  logic         busy;

  modport slave (
    input  req, lst, d0, d1, d2, d3, out_ready,
    output ack, out_valid, out_data, out_last, out_src, busy
  );

  modport master (
    output req, lst, d0, d1, d2, d3, out_ready,
    input  ack, out_valid, out_data, out_last, out_src, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Packet-level round-robin 4:1 mux: the winner keeps the output until its last beat.
// Latency: 1 cycle arbitration, then ack and registered output beat 1 cycle after ack.
// Backpressure: beats are acked only when the output register is empty or draining.
module rr_mux_arbiter #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  rr_mux_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t       state, state_nxt;
  logic [1:0]   owner, owner_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic         busy_q, busy_nxt;

  logic [1:0]   pick;
  logic         pick_vld;
  logic         accept;
  logic [3:0]   ack_w;
  logic [N-1:0] sel_d;

  logic         out_valid_q;
  logic [N-1:0] out_data_q;
  logic         out_last_q;
  logic [1:0]   out_src_q;

  // Round-robin search starting just after the last served requester; nearest wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        pick     = ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  // 4:1 data mux indexed by the locked owner.
  always_comb begin
    sel_d = bus.d0;
    case (owner)
      2'd0: sel_d = bus.d0;
      2'd1: sel_d = bus.d1;
      2'd2: sel_d = bus.d2;
      2'd3: sel_d = bus.d3;
      default: sel_d = bus.d0;
    endcase
  end

  // Owner's beat is consumed when it is present and the output register can take it.
  always_comb begin
    accept = (state == LOCK) && bus.req[owner] && (!out_valid_q || bus.out_ready);
    ack_w  = 4'd0;
    if (accept) ack_w[owner] = 1'b1;
  end

  // Next-state: lock onto a winner in IDLE, release on the accepted last beat.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    busy_nxt  = busy_q;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          state_nxt = LOCK;
          busy_nxt  = 1'b1;
        end
      end
      LOCK: begin
        if (accept && bus.lst[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = owner;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Control state; ptr resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 2'd0;
      ptr    <= 2'd3;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      ptr    <= ptr_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Output register: load on accept, empty on drain, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 2'd0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_d;
      out_last_q  <= bus.lst[owner];
      out_src_q   <= owner;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.ack       = ack_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with an expected-beat queue checked by a monitor.
module tb_rr_mux_arbiter;

  localparam int N = 8;

  typedef struct packed {
    logic [1:0]   src;
    logic [N-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_mux_arbiter_if #(.N(N)) bus ();

  rr_mux_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [N-1:0] d, input logic l);
    beat_t b;
    b.src  = s;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Pops one expected beat for every beat the sink actually takes.
  task automatic monitor();
    beat_t e;
    beat_t a;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        a.src  = bus.out_src;
        a.data = bus.out_data;
        a.last = bus.out_last;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat: unexpected beat got=%0h expected=none", a);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'(a), 32'(e));
        end
      end
    end
  endtask

  // Waits (bounded) for a nonzero ack, checks it, then steps past the accepting edge.
  task automatic wait_ack(input logic [3:0] exp, input string nm, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.ack != 4'd0) break;
      waited++;
      if (waited > 20) begin
        total++;
        bad++;
        $display("FAIL %s: got=no ack expected=%0h", nm, exp);
        return;
      end
    end
    chk(nm, 32'(bus.ack), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bus.req = 4'd0; bus.lst = 4'd0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
    bus.out_ready = 1'b1;

    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values while held
    #7;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    chk("rst_src",   32'(bus.out_src), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_ack",   32'(bus.ack), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ack_valid_busy", 32'({bus.ack, bus.out_valid, bus.busy}), 0);
    end
    step();

    // All request, single-beat packets: order 0,1,2,3,0
    push(2'd0, 8'h10, 1'b1); push(2'd1, 8'h11, 1'b1); push(2'd2, 8'h12, 1'b1);
    push(2'd3, 8'h13, 1'b1); push(2'd0, 8'h10, 1'b1);
    bus.req = 4'b1111; bus.lst = 4'b1111;
    bus.d0 = 8'h10; bus.d1 = 8'h11; bus.d2 = 8'h12; bus.d3 = 8'h13;
    wait_ack(4'b0001, "rr_g0", w);
    chk("first_ack_latency", 32'(w), 1);
    wait_ack(4'b0010, "rr_g1", w);
    wait_ack(4'b0100, "rr_g2", w);
    wait_ack(4'b1000, "rr_g3", w);
    wait_ack(4'b0001, "rr_g0b", w);
    bus.req = 4'd0;
    step();

    // Requester 2 three-beat packet while requester 0 waits
    push(2'd2, 8'hA1, 1'b0); push(2'd2, 8'hA2, 1'b0); push(2'd2, 8'hA3, 1'b1);
    push(2'd0, 8'h50, 1'b1);
    bus.req = 4'b0101; bus.lst = 4'b0001; bus.d0 = 8'h50; bus.d2 = 8'hA1;
    wait_ack(4'b0100, "pkt_a1", w);
    bus.d2 = 8'hA2;
    chk("pkt_busy", 32'(bus.busy), 1);
    wait_ack(4'b0100, "pkt_a2", w);
    chk("pkt_a2_back2back", 32'(w), 0);
    bus.d2 = 8'hA3; bus.lst = 4'b0101;
    wait_ack(4'b0100, "pkt_a3", w);
    chk("pkt_a3_back2back", 32'(w), 0);
    bus.req = 4'b0001;
    wait_ack(4'b0001, "pkt_then_r0", w);
    bus.req = 4'd0;
    step();

    // Output stall for 4 cycles during requester 3 packet
    push(2'd3, 8'hB1, 1'b0); push(2'd3, 8'hB2, 1'b0); push(2'd3, 8'hB3, 1'b1);
    bus.req = 4'b1000; bus.lst = 4'b0000; bus.d3 = 8'hB1;
    wait_ack(4'b1000, "stall_b1", w);
    bus.out_ready = 1'b0; bus.d3 = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ack", 32'(bus.ack), 0);
      chk("stall_hold", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'hB1}));
      step();
    end
    bus.out_ready = 1'b1;
    wait_ack(4'b1000, "stall_b2", w);
    chk("stall_resume", 32'(w), 0);
    bus.d3 = 8'hB3; bus.lst = 4'b1000;
    wait_ack(4'b1000, "stall_b3", w);
    bus.req = 4'd0;
    step();

    // Owner drops req for 2 cycles while requester 1 waits
    push(2'd0, 8'hC1, 1'b0); push(2'd0, 8'hC2, 1'b1); push(2'd1, 8'h77, 1'b1);
    bus.req = 4'b0011; bus.lst = 4'b0010; bus.d0 = 8'hC1; bus.d1 = 8'h77;
    wait_ack(4'b0001, "gap_c1", w);
    bus.req = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("gap_ack", 32'(bus.ack), 0);
      chk("gap_busy", 32'(bus.busy), 1);
      step();
    end
    bus.req = 4'b0011; bus.d0 = 8'hC2; bus.lst = 4'b0011;
    wait_ack(4'b0001, "gap_c2", w);
    chk("gap_owner_kept", 32'(w), 0);
    bus.req = 4'b0010;
    wait_ack(4'b0010, "gap_then_r1", w);
    bus.req = 4'd0;
    step();

    // Reset mid-packet, then 1010 must grant requester 1
    push(2'd2, 8'hD1, 1'b0);
    bus.req = 4'b0100; bus.lst = 4'b0000; bus.d2 = 8'hD1;
    wait_ack(4'b0100, "rst_pkt_d1", w);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outs", 32'({bus.out_valid, bus.out_data, bus.out_last, bus.out_src}), 0);
    chk("midrst_busy_ack", 32'({bus.busy, bus.ack}), 0);
    push(2'd1, 8'hE1, 1'b1);
    bus.req = 4'b1010; bus.lst = 4'b1010; bus.d1 = 8'hE1; bus.d3 = 8'hE3;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ack(4'b0010, "post_rst_grant", w);
    bus.req = 4'd0;

    repeat (4) step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 8: data width of every requester and of the output.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  req[i] = requester i presents a valid beat on d<i>.
REQ-005 lst  input  4  lst[i] = beat on d<i> is the last beat of its packet.
REQ-006 d0, d1, d2, d3  input  N each  requester data.
REQ-007 ack  output  4  one-hot, combinational; ack[i]=1 means requester i's beat is consumed this cycle.
REQ-008 out_ready  input  1  downstream can accept the output beat.
REQ-009 out_valid  output  1  registered; output beat valid.
REQ-010 out_data  output  N  registered; selected beat data.
REQ-011 out_last  output  1  registered; copy of the selected lst bit.
REQ-012 out_src  output  2  registered; index of the requester that produced the beat.
REQ-013 busy  output  1  registered; 1 while a packet owner is locked.

Function
REQ-014 FSM states: IDLE, LOCK; a 2-bit owner register and a 2-bit round-robin pointer ptr (last served requester).
REQ-015 IDLE: if req != 0, owner <= first i with req[i]=1, searching ptr+1, ptr+2, ptr+3, ptr (mod 4); state <= LOCK; busy <= 1; ack = 0 in IDLE.
REQ-016 IDLE with req == 0: remain in IDLE; no state change.
REQ-017 LOCK, accept condition: req[owner]=1 and (out_valid=0 or out_ready=1).
REQ-018 On accept: ack[owner]=1 in the same cycle; next edge out_data <= d<owner>, out_last <= lst[owner], out_src <= owner, out_valid <= 1.
REQ-019 Data selection is equivalent to a 4:1 mux indexed by owner (00->d0 ... 11->d3).
REQ-020 Accept with lst[owner]=1: state <= IDLE, ptr <= owner, busy <= 0 at the same edge.
REQ-021 LOCK with req[owner]=0: hold owner; no ack; other requesters wait (packets never interleave).
REQ-022 Without a new accept: out_valid <= 0 when out_ready=1; output registers hold when out_ready=0.
REQ-023 Output registers never change while out_valid=1 and out_ready=0.
REQ-024 Latency: the first beat is accepted 1 cycle after arbitration (the IDLE cycle); it appears on out_* 1 cycle after its ack.
REQ-025 Throughput: 1 beat per cycle in LOCK while req[owner]=1 and out_ready=1.
REQ-026 Fairness: a continuously requesting input waits at most 3 packets.
REQ-027 Single-beat packet (lst=1 on the first beat) is legal: LOCK lasts 1 accept cycle.
REQ-028 Changes on non-owner req/lst/d inputs have no effect in LOCK.

Reset
REQ-029 While rst=1 (asynchronously): state=IDLE, owner=0, ptr=3, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0; ack=0.
REQ-030 Reset asserted mid-packet aborts it; after release, arbitration restarts with requester 0 at highest priority.

Verification
REQ-031 Reset, then req=4'b1111 with each requester sending 1-beat packets -> grant order 0,1,2,3,0; out_src sequence 0,1,2,3,0.
REQ-032 N=8; req[2] sends a 3-beat packet A1,A2,A3 (lst on A3) while req[0] is held high -> out_data A1,A2,A3 with out_src=2 on consecutive cycles, then requester 0 is served; no interleave.
REQ-033 out_ready=0 for 4 cycles during a packet -> out_data is stable, out_valid=1, ack=0 after the register fills; traffic resumes without loss or duplication.
REQ-034 Owner deasserts req mid-packet for 2 cycles while req[1]=1 -> no ack, busy stays 1, owner is unchanged.
REQ-035 rst pulsed mid-packet -> all outputs are 0 immediately; next arbitration with req=4'b1010 grants requester 1.
REQ-036 req=0 for 10 cycles after reset -> state IDLE, ack=0, out_valid=0 throughout.
